// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared types and helpers for the serial adder.
//                - state_t      : control FSM state encoding (IDLE/RUN/DONE)
//                - cnt_width()  : bits needed for a 0..steps-1 step counter
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0..steps-1. The result is never
    // below 1, so a single-step configuration still has a legal counter.
    function automatic int cnt_width(input int steps);
        int w;
        w = 1;
        while ((1 << w) < steps) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : digit_adder
//  Description : Combinational DIGIT-bit ripple-carry adder slice.
//  Ports       : x, y  [DIGIT-1:0] in  - operand digits
//                ci               in  - carry in
//                s     [DIGIT-1:0] out - sum digit
//                co               out - carry out of the top bit
//  Revision    : 1.0 - initial release
// ============================================================================
module digit_adder
    import serial_adder_pkg::*;
#(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co
);

    // w_c[i] is the carry into bit i
    logic [DIGIT:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign co = w_c[DIGIT];

endmodule : digit_adder
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Digit-serial adder, sum = a + b + cin (mod 2^WIDTH), DIGIT
//                bits per cycle, LSB digit first, valid/ready on both sides.
//  Parameters  : WIDTH (2..64), DIGIT (must divide WIDTH)
//  Ports       : clk, rst_n (async, active low)
//                in_valid/in_ready, a, b, cin    - operand handshake
//                out_valid/out_ready, sum, cout  - result handshake
//                ovf (only with SERIAL_ADDER_OVF_EN) - signed overflow
//  Options     : `define SERIAL_ADDER_OVF_EN adds the ovf output.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = cnt_width(STEPS);

    if ((WIDTH < 2) || (WIDTH > 64) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_err
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             r_ovf;
`endif

    logic [DIGIT-1:0] w_x;
    logic [DIGIT-1:0] w_y;
    logic [DIGIT-1:0] w_s;
    logic             w_co;
    logic             w_last;

    // Select captured digit r_cnt of each operand.
    always_comb begin
        w_x = '0;
        w_y = '0;
        for (int k = 0; k < STEPS; k++) begin
            if (r_cnt == CW'(k)) begin
                w_x = r_a[k*DIGIT +: DIGIT];
                w_y = r_b[k*DIGIT +: DIGIT];
            end
        end
    end

    assign w_last = (r_cnt == CW'(STEPS - 1));

    digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit_adder (
        .x  (w_x),
        .y  (w_y),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_cnt   <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    for (int k = 0; k < STEPS; k++) begin
                        if (r_cnt == CW'(k)) begin
                            r_sum[k*DIGIT +: DIGIT] <= w_s;
                        end
                    end
                    r_carry <= w_co;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout  <= w_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // Equal operand signs with a differing result sign is
                        // exactly carry-into-MSB XOR carry-out-of-MSB.
                        r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                                   (w_s[DIGIT-1] != r_a[WIDTH-1]);
`endif
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf       = r_ovf;
`endif

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder. Three instances:
//                u_w8d1 (WIDTH=8,DIGIT=1), u_w8d4 (WIDTH=8,DIGIT=4) and
//                u_w4d2 (WIDTH=4,DIGIT=2), checked against an arithmetic
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic [2:0] iv;
    logic [2:0] ordy;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    wire  [2:0] ir;
    wire  [2:0] ov;
    wire  [2:0] co;
    wire  [7:0] sum0;
    wire  [7:0] sum1;
    wire  [3:0] sum2;
`ifdef SERIAL_ADDER_OVF_EN
    wire  [2:0] ovf_v;
`endif

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(ordy[0]),
        .sum(sum0),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[0]),
`endif
        .cout(co[0])
    );

    serial_adder #(.WIDTH(8), .DIGIT(4)) u_w8d4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a), .b(b), .cin(cin), .out_valid(ov[1]), .out_ready(ordy[1]),
        .sum(sum1),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[1]),
`endif
        .cout(co[1])
    );

    serial_adder #(.WIDTH(4), .DIGIT(2)) u_w4d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a[3:0]), .b(b[3:0]), .cin(cin), .out_valid(ov[2]), .out_ready(ordy[2]),
        .sum(sum2),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf(ovf_v[2]),
`endif
        .cout(co[2])
    );

    function automatic logic [7:0] dsum(input int idx);
        case (idx)
            0:       return sum0;
            1:       return sum1;
            default: return {4'b0000, sum2};
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete transaction on instance idx, checked against plain
    // integer arithmetic; the DONE state is held for 'stall' cycles.
    task automatic do_add(input int idx, input logic [7:0] av, input logic [7:0] bv,
                          input logic ci, input int stall);
        int  w, steps, n, lat, ua, ub, full, sa, sb, sv;
        logic [7:0] es;
        logic ec, eo;
        w     = (idx == 2) ? 4 : 8;
        steps = (idx == 0) ? 8 : 2;
        ua    = int'(av) % (1 << w);
        ub    = int'(bv) % (1 << w);
        full  = ua + ub + int'(ci);
        es    = 8'(full % (1 << w));
        ec    = (full >= (1 << w));
        sa    = (ua >= (1 << (w-1))) ? ua - (1 << w) : ua;
        sb    = (ub >= (1 << (w-1))) ? ub - (1 << w) : ub;
        sv    = sa + sb + int'(ci);
        eo    = (sv > (1 << (w-1)) - 1) || (sv < -(1 << (w-1)));

        n = 0;
        while (!ir[idx] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_before_accept", 64'(ir[idx]), 64'd1);

        a = av; b = bv; cin = ci; iv[idx] = 1'b1;
        @(posedge clk); #1;
        // Operands change right after acceptance and must not matter.
        a = 8'hFF; b = 8'($urandom); cin = ~ci;
        check("in_ready_in_run", 64'(ir[idx]), 64'd0);

        lat = 0;
        while (!ov[idx] && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
        iv[idx] = 1'b0;
        check("latency", 64'(lat), 64'(steps));
        check("sum", 64'(dsum(idx)), 64'(es));
        check("cout", 64'(co[idx]), 64'(ec));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 64'(ovf_v[idx]), 64'(eo));
`else
        if (eo) n = 0;
`endif

        for (int s = 0; s < stall; s++) begin
            ordy[idx] = 1'b0;
            iv[idx]   = 1'b1;
            @(posedge clk); #1;
            check("stall_out_valid", 64'(ov[idx]), 64'd1);
            check("stall_in_ready", 64'(ir[idx]), 64'd0);
            check("stall_sum", 64'(dsum(idx)), 64'(es));
            check("stall_cout", 64'(co[idx]), 64'(ec));
        end

        // in_valid held high across the handshake edge must not be accepted.
        iv[idx] = 1'b1; ordy[idx] = 1'b1;
        @(posedge clk); #1;
        iv[idx] = 1'b0; ordy[idx] = 1'b0;
        check("post_hs_out_valid", 64'(ov[idx]), 64'd0);
        check("post_hs_in_ready", 64'(ir[idx]), 64'd1);
        check("post_hs_sum_hold", 64'(dsum(idx)), 64'(es));
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; iv = '0; ordy = '0; a = '0; b = '0; cin = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", 64'(ov), 64'd0);
        check("rst_sum0", 64'(sum0), 64'd0);
        check("rst_sum1", 64'(sum1), 64'd0);
        check("rst_sum2", 64'(sum2), 64'd0);
        check("rst_cout", 64'(co), 64'd0);
        #10 rst_n = 1'b1;
        #1;
        check("rst_in_ready", 64'(ir), 64'd7);

        // Directed cases
        do_add(0, 8'hFF, 8'h01, 1'b0, 0);
        do_add(1, 8'h3C, 8'h45, 1'b1, 0);
        do_add(1, 8'h80, 8'h80, 1'b0, 5);
        do_add(0, 8'h7F, 8'h00, 1'b1, 5);
        do_add(0, 8'h10, 8'h20, 1'b0, 2);

        // Reset in the middle of RUN
        a = 8'hAA; b = 8'h55; cin = 1'b0; iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(ov[0]), 64'd0);
        check("midrun_rst_sum", 64'(sum0), 64'd0);
        check("midrun_rst_cout", 64'(co[0]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrun_rel_in_ready", 64'(ir[0]), 64'd1);
        bad = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (ov[0]) bad++;
        end
        check("midrun_no_spurious_valid", 64'(bad), 64'd0);
        do_add(0, 8'h01, 8'h01, 1'b0, 0);

        // Random traffic on the 8-bit instances
        for (int i = 0; i < 20; i++) begin
            do_add(0, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
            do_add(1, 8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
        end

        // Exhaustive 4-bit sweep with random result back-pressure
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                for (int c = 0; c < 2; c++) begin
                    do_add(2, 8'(x), 8'(y), 1'(c), int'($urandom_range(0, 2)));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_adder
`default_nettype wire

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and sum width in bits; legal values 2..64.
REQ-002 Parameter DIGIT, default 1: bits added per cycle; SHALL divide WIDTH exactly, else elaboration error.
REQ-003 Port clk  input  1: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-005 Port in_valid  input  1: operands and carry-in presented.
REQ-006 Port in_ready  output  1: block can accept operands.
REQ-007 Port a  input  WIDTH: operand A, unsigned or two's complement.
REQ-008 Port b  input  WIDTH: operand B.
REQ-009 Port cin  input  1: carry-in.
REQ-010 Port out_valid  output  1: sum and cout hold a completed result.
REQ-011 Port out_ready  input  1: consumer accepts the result.
REQ-012 Port sum  output  WIDTH: a + b + cin modulo 2^WIDTH.
REQ-013 Port cout  output  1: carry out of bit WIDTH-1.

Function
REQ-014 FSM states: IDLE, RUN, DONE; STEPS = WIDTH/DIGIT.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 IDLE: on an edge with in_valid && in_ready, capture a, b and cin into internal registers, clear the step counter, and go to RUN.
REQ-017 RUN: each edge adds captured digit k of a and b plus the carry register, writes DIGIT result bits into sum bits [k*DIGIT +: DIGIT], updates the carry, and increments k (LSB digit first).
REQ-018 RUN to DONE SHALL occur on the edge that processes digit STEPS-1; out_valid rises exactly STEPS edges after the accepting edge.
REQ-019 DONE: sum and cout SHALL remain stable; on an edge with out_ready=1, go to IDLE.
REQ-020 No accept on the DONE-to-IDLE edge; the earliest next accept is one edge later (peak throughput one result per STEPS+2 cycles).
REQ-021 in_valid, a, b and cin SHALL be ignored outside IDLE; changes after acceptance SHALL not affect the result.
REQ-022 out_ready SHALL be ignored outside DONE.
REQ-023 sum and cout SHALL hold the last result after handshake until the next RUN overwrites them; partial bits are visible during RUN but are invalid.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, in_ready=1 after release, out_valid=0, sum=0, cout=0, counter=0, carry=0.
REQ-025 Reset mid-RUN or mid-DONE SHALL discard the operation; no out_valid may follow without a new accept.

Configuration
REQ-026 Macro SERIAL_ADDER_OVF_EN defined: add output port ovf (1 bit, reset 0) = signed overflow (carry into MSB XOR carry out), valid and stable while out_valid=1.
REQ-027 Macro undefined: no ovf port and no overflow logic; all other behaviour identical.

Structure
REQ-028 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE, RUN, DONE) and a width-of-counter helper function.
REQ-029 One sub-module digit_adder (parameter DIGIT; inputs x, y, ci; outputs s, co) SHALL implement the per-cycle DIGIT-bit ripple add; the FSM, counter and registers stay in serial_adder.

Verification
REQ-030 WIDTH=8, DIGIT=1: a=0xFF, b=0x01, cin=0 -> out_valid 8 edges after accept, sum=0x00, cout=1.
REQ-031 WIDTH=8, DIGIT=4: a=0x3C, b=0x45, cin=1 -> out_valid 2 edges after accept, sum=0x82, cout=0; with SERIAL_ADDER_OVF_EN, ovf=1.
REQ-032 Back-pressure: hold out_ready=0 for 5 cycles in DONE -> sum, cout and out_valid stay constant; in_ready stays 0; in_valid pulses ignored.
REQ-033 Operand change after accept: accept a=0x10, b=0x20, then drive a=0xFF during RUN -> sum=0x30, cout=0.
REQ-034 Reset mid-RUN: assert rst_n=0 at step 3 of 8 -> out_valid=0, sum=0 at once, in_ready=1 after release, then a fresh add of 0x01+0x01 yields 0x02.
REQ-035 Exhaustive sweep WIDTH=4, DIGIT=2, all a, b and cin with random out_ready -> every result matches a reference model.
